// File: rtl/counter_nbit_ud_pkg.sv
// Shared definitions for the counter primitive family: mode/direction
// encodings and the single-step next-count function.
package counter_pkg;

  localparam int   CNT_WRAP  = 0;
  localparam int   CNT_SAT   = 1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  // Widest supported counter; the step math runs one bit wider so that a
  // modulus of 2**CNT_MAX_W is still representable.
  localparam int   CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W:0] cnt_wide_t;

  typedef struct packed {
    cnt_wide_t next;
    logic      term;
  } cnt_step_t;

  // One enabled step in the given direction; term flags a wrap or a
  // blocked step at a bound.
  function automatic cnt_step_t cnt_step(input cnt_wide_t count,
                                         input logic      up_dn,
                                         input cnt_wide_t modulus,
                                         input logic      saturate);
    cnt_step_t r;
    cnt_wide_t last;
    last   = modulus - 33'd1;
    r.next = count;
    r.term = 1'b0;
    if (up_dn == DIR_UP) begin
      if (count >= last) begin
        r.term = 1'b1;
        if (saturate) begin
          r.next = count;
        end else begin
          r.next = 33'd0;
        end
      end else begin
        r.next = count + 33'd1;
      end
    end else begin
      if (count == 33'd0) begin
        r.term = 1'b1;
        if (saturate) begin
          r.next = count;
        end else begin
          r.next = last;
        end
      end else begin
        r.next = count - 33'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_nbit_ud_if.sv
// Control/status bundle of the up/down counter. The master side drives the
// controls and observes the count; the counter itself is the slave.
interface counter_nbit_ud_if #(
  parameter int WIDTH = 5
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  out, tc, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output out, tc, load_err
  );
endinterface

// File: rtl/counter_nbit_ud_next_val.sv
// Combinational next-count generator: one step up or down from the current
// count, wrapping or saturating at the bounds.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 5,
  parameter longint unsigned MODULUS  = 32,
  parameter int              SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] next_cnt,
  output logic             wrap
);

  localparam cnt_wide_t MOD_W = cnt_wide_t'(MODULUS);
  localparam logic      SAT_B = (SATURATE == CNT_SAT) ? 1'b1 : 1'b0;

  cnt_wide_t count_w_s;
  cnt_step_t step_s;

  // Widen the count, take one step, and narrow the result back.
  always_comb begin
    count_w_s = cnt_wide_t'(count);
    step_s    = cnt_step(count_w_s, up_dn, MOD_W, SAT_B);
    next_cnt  = step_s.next[WIDTH-1:0];
    wrap      = step_s.term;
  end

endmodule

// File: rtl/counter_nbit_ud.sv
// Parametrised up/down counter with clear, parallel load, enable,
// wrap/saturate mode, terminal-count pulse and load range error pulse.
module counter_nbit_ud
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 5,
  parameter longint unsigned MODULUS  = 32,
  parameter int              SATURATE = CNT_WRAP,
  parameter longint unsigned RST_VAL  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  counter_nbit_ud_if.slave  bus
);

  // Reject illegal parameter sets at elaboration.
  if (WIDTH < 2 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("counter_nbit_ud: WIDTH must be in 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_nbit_ud: MODULUS must be in 2..2**WIDTH");
  end
  if (RST_VAL >= MODULUS) begin : g_bad_rst_val
    $error("counter_nbit_ud: RST_VAL must be below MODULUS");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("counter_nbit_ud: SATURATE must be 0 or 1");
  end

  // Modulus kept one bit wider than the count so 2**WIDTH fits.
  localparam logic [WIDTH:0]   MOD_P    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] out_r;
  logic             tc_r;
  logic             load_err_r;
  logic [WIDTH-1:0] out_nxt_s;
  logic             tc_nxt_s;
  logic             err_nxt_s;
  logic [WIDTH-1:0] step_nxt_s;
  logic             step_wrap_s;
  logic             load_oor_s;

  counter_next_val #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .count    (out_r),
    .up_dn    (bus.up_dn),
    .next_cnt (step_nxt_s),
    .wrap     (step_wrap_s)
  );

  assign load_oor_s = ({1'b0, bus.load_val} >= MOD_P);

  // Priority selection of the next state: clr > load > en > hold.
  always_comb begin
    out_nxt_s = out_r;
    tc_nxt_s  = 1'b0;
    err_nxt_s = 1'b0;
    if (bus.clr) begin
      out_nxt_s = RST_V;
    end else if (bus.load) begin
      if (load_oor_s) begin
        out_nxt_s = LAST_VAL;
        err_nxt_s = 1'b1;
      end else begin
        out_nxt_s = bus.load_val;
      end
    end else if (bus.en) begin
      out_nxt_s = step_nxt_s;
      tc_nxt_s  = step_wrap_s;
    end else begin
      out_nxt_s = out_r;
    end
  end

  // Count and pulse registers, asynchronously forced on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_r      <= RST_V;
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      out_r      <= out_nxt_s;
      tc_r       <= tc_nxt_s;
      load_err_r <= err_nxt_s;
    end
  end

  assign bus.out      = out_r;
  assign bus.tc       = tc_r;
  assign bus.load_err = load_err_r;

endmodule

// File: doc/counter_nbit_ud.md
Name: counter_nbit_ud

Overview:
- Parametrised successor to the 5-bit up-counter.
- Generalised width and modulus; adds up/down direction, synchronous clear, parallel load, count enable, wrap/saturate mode and a terminal-count pulse.
- Used as the counter primitive for the Ngveri/NGHDL model set (timers, address generators, event counters).
- Single clock domain; no internal clock gating.

Parameters:
- WIDTH, 5: counter width in bits; legal range 2..32.
- MODULUS, 32: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.
- RST_VAL, 0: value of out on reset and on clr; must be < MODULUS.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rstn, input, 1: asynchronous active-low reset.
- en, input, 1: count enable; one step per clk while high.
- up_dn, input, 1: direction; 1 = up, 0 = down.
- clr, input, 1: synchronous clear to RST_VAL.
- load, input, 1: synchronous parallel load.
- load_val, input, WIDTH: value to load.
- out, output, WIDTH: current count (registered).
- tc, output, 1: terminal-count pulse (registered).
- load_err, output, 1: load value was out of range (registered pulse).

Behaviour:
- Reset:
  - rstn low forces out=RST_VAL, tc=0, load_err=0 immediately, independent of clk.
  - Deassertion is treated as synchronous by the integrator; the block has no synchroniser.
- Priority at each rising edge: clr > load > en > hold.
  - clr=1: out<=RST_VAL; tc<=0; load_err<=0; load and en are ignored.
  - load=1 (clr=0), load_val<MODULUS: out<=load_val; tc<=0; load_err<=0.
  - load=1 (clr=0), load_val>=MODULUS: out<=MODULUS-1; load_err<=1 for exactly one cycle; tc<=0.
  - en=1 (clr=0, load=0): one step in the up_dn direction, per the rules below.
  - Otherwise: out holds; tc<=0; load_err<=0.
- Up step:
  - out<MODULUS-1: out<=out+1, tc<=0.
  - out==MODULUS-1, SATURATE=0: out<=0, tc<=1.
  - out==MODULUS-1, SATURATE=1: out holds, tc<=1 (repeats every enabled cycle while pinned).
- Down step:
  - out>0: out<=out-1, tc<=0.
  - out==0, SATURATE=0: out<=MODULUS-1, tc<=1.
  - out==0, SATURATE=1: out holds, tc<=1.
- tc timing:
  - tc is high in the cycle where out first shows the post-wrap value, or in the cycle after a blocked saturating step.
  - tc is never asserted by clr, load, or reset.
- Direction change: up_dn may change on any cycle. The step uses the up_dn value sampled at that edge; no pipeline, latency 1 cycle from en to out.
- Arithmetic:
  - Compare against MODULUS-1 computed at WIDTH+1 bits, so MODULUS=2**WIDTH is legal.
  - out never holds a value >=MODULUS.
- Inputs are sampled only at the clock edge; combinational glitches between edges have no effect.
- Parameter legality is checked at elaboration with an error on violation: MODULUS>2**WIDTH, RST_VAL>=MODULUS, WIDTH<2.

Decomposition:
- Package counter_pkg:
  - Localparams for mode encoding: CNT_WRAP=0, CNT_SAT=1.
  - Direction constants: DIR_UP=1, DIR_DN=0.
  - A function computing the next count and the terminal flag from (count, up_dn, MODULUS, SATURATE), shared with future counter variants.
- One combinational sub-module, counter_next_val:
  - Inputs: current count, up_dn, parameters.
  - Outputs: next count and wrap flag.
  - The top level holds the registers, the priority mux and the load range check.

Test Plan:
- Reset / clear: defaults, en=1 for 5 cycles so out=5; assert rstn low mid-cycle, then out=0 immediately; after release, en=1 for 3 cycles so out=3; then clr=1 with en=1, so out=0 next edge and tc=0.
- Up wrap: MODULUS=20, SATURATE=0, up_dn=1, load 18 then en: out 19, 0, 1; tc=1 only in the cycle out=0.
- Down wrap / saturate:
  - SATURATE=0, out=1, up_dn=0: out 0, 19; tc high with 19.
  - SATURATE=1, same stimulus: out 0, 0, 0; tc high on each enabled cycle at 0.
- Load range: MODULUS=20, load_val=25, so out=19 and load_err=1 for one cycle; load_val=7 gives out=7 and load_err=0. With load=1, en=1 and clr=0, load wins: out=7.
- Enable / hold and direction flip:
  - en toggled 1,0,1 from 0 gives out 1,1,2.
  - up_dn flipped every cycle with en=1 from 10 gives out 11,10,11,10; tc stays 0.
- Full-range width: WIDTH=5, MODULUS=32: from 31 up gives 0 with tc=1; verifies the 2**WIDTH edge case without overflow.
